// File: rtl/unsigned_divider.sv
// unsigned_divider: radix-2 restoring unsigned divider, one quotient bit per clock.
//   Ports: clk, rstn (async active-low), start, dividend[WIDTH], divisor[WIDTH] in;
//          busy (RUN state), done (one-cycle pulse), quotient[WIDTH], remainder[WIDTH] out.
//   Macro DIV_BY_ZERO_BYPASS_EN: when defined, divisor=0 skips RUN and completes the next cycle.
module unsigned_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  // dvd_q doubles as the quotient accumulator: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    ge      = shifted >= {1'b0, dsr_q};
    rem_nx  = ge ? shifted[WIDTH-1:0] - dsr_q : shifted[WIDTH-1:0];
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rout_d  = rout_q;
    case (state_q)
      IDLE: if (start) begin
        dvd_d   = dividend;
        dsr_d   = divisor;
        rem_d   = '0;
        cnt_d   = CW'(WIDTH);
        state_d = RUN;
`ifdef DIV_BY_ZERO_BYPASS_EN
        if (divisor == '0) begin
          state_d = DONE;
          quo_d   = '1;
          rout_d  = dividend;
        end
`else
`endif
      end
      RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        rem_d = rem_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = {dvd_q[WIDTH-2:0], ge};
          rout_d  = rem_nx;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rout_q  <= rout_d;
    end
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign quotient  = quo_q;
  assign remainder = rout_q;
endmodule

// File: tb/tb_unsigned_divider.sv
// tb_unsigned_divider: directed self-checking bench for unsigned_divider (WIDTH=32).
module tb_unsigned_divider;
`ifdef DIV_BY_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] quotient, remainder;
  int          vectors = 0;
  int          errors = 0;

  unsigned_divider #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Call just after a negedge; returns #1 after the sampling edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // n = negedges after the start edge up to and including the done cycle;
  // then advances one more negedge into the following IDLE cycle.
  task automatic wait_done(output int n, output int b);
    n = 0; b = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) b++;
    end while (!done && n < 100);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #3;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    vectors++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quot got %h want 0", quotient); end
    vectors++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_rem got %h want 0", remainder); end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n, b;
    start_op(32'd100, 32'd7);
    wait_done(n, b);
    vectors++; if (n !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", n); end
    vectors++; if (b !== 32) begin errors++; $display("FAIL basic_busy_cycles got %0d want 32", b); end
    vectors++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_quot got %0d want 14", quotient); end
    vectors++; if (remainder !== 32'd2) begin errors++; $display("FAIL basic_rem got %0d want 2", remainder); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_single got %0b want 0", done); end
  endtask

  task automatic test_extremes;
    int n, b;
    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done(n, b);
    vectors++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_div1_quot got %h want ffffffff", quotient); end
    vectors++; if (remainder !== 32'd0) begin errors++; $display("FAIL max_div1_rem got %h want 0", remainder); end
    start_op(32'd5, 32'd9);
    wait_done(n, b);
    vectors++; if (quotient !== 32'd0) begin errors++; $display("FAIL small_quot got %0d want 0", quotient); end
    vectors++; if (remainder !== 32'd5) begin errors++; $display("FAIL small_rem got %0d want 5", remainder); end
  endtask

  task automatic test_div_zero;
    int n, b;
    start_op(32'h1234_5678, 32'd0);
    wait_done(n, b);
    vectors++; if (n !== ZLAT) begin errors++; $display("FAIL divzero_latency got %0d want %0d", n, ZLAT); end
    vectors++; if (b !== ZLAT - 1) begin errors++; $display("FAIL divzero_busy_cycles got %0d want %0d", b, ZLAT - 1); end
    vectors++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divzero_quot got %h want ffffffff", quotient); end
    vectors++; if (remainder !== 32'h1234_5678) begin errors++; $display("FAIL divzero_rem got %h want 12345678", remainder); end
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    int first = 0;
    start_op(32'd200, 32'd9);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (done) begin pulses++; if (first == 0) first = n; end
      if (n == 10) begin start = 1'b1; dividend = 32'd7; divisor = 32'd2; end
      if (n == 11) start = 1'b0;
      if (n == 20) begin
        vectors++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL hold_quot_in_run got %h want ffffffff", quotient); end
        vectors++; if (remainder !== 32'h1234_5678) begin errors++; $display("FAIL hold_rem_in_run got %h want 12345678", remainder); end
      end
    end
    vectors++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    vectors++; if (first !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", first); end
    vectors++; if (quotient !== 32'd22) begin errors++; $display("FAIL ignore_quot got %0d want 22", quotient); end
    vectors++; if (remainder !== 32'd2) begin errors++; $display("FAIL ignore_rem got %0d want 2", remainder); end
  endtask

  task automatic test_reset_mid_run;
    int n, b;
    int seen = 0;
    start_op(32'd100, 32'd7);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    rstn = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b want 0", done); end
    vectors++; if (quotient !== 32'd0) begin errors++; $display("FAIL midrst_quot got %h want 0", quotient); end
    vectors++; if (remainder !== 32'd0) begin errors++; $display("FAIL midrst_rem got %h want 0", remainder); end
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    vectors++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", seen); end
    start_op(32'd1000, 32'd10);
    wait_done(n, b);
    vectors++; if (n !== 33) begin errors++; $display("FAIL postrst_latency got %0d want 33", n); end
    vectors++; if (quotient !== 32'd100) begin errors++; $display("FAIL postrst_quot got %0d want 100", quotient); end
    vectors++; if (remainder !== 32'd0) begin errors++; $display("FAIL postrst_rem got %0d want 0", remainder); end
  endtask

  task automatic test_back_to_back;
    int n1, n2, b;
    start_op(32'd50, 32'd3);
    wait_done(n1, b);
    vectors++; if (quotient !== 32'd16) begin errors++; $display("FAIL b2b_first_quot got %0d want 16", quotient); end
    vectors++; if (remainder !== 32'd2) begin errors++; $display("FAIL b2b_first_rem got %0d want 2", remainder); end
    start_op(32'd50, 32'd4);
    wait_done(n2, b);
    vectors++; if (n2 + 1 !== 34) begin errors++; $display("FAIL b2b_gap got %0d want 34", n2 + 1); end
    vectors++; if (quotient !== 32'd12) begin errors++; $display("FAIL b2b_second_quot got %0d want 12", quotient); end
    vectors++; if (remainder !== 32'd2) begin errors++; $display("FAIL b2b_second_rem got %0d want 2", remainder); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_div_zero;
    test_ignore_start;
    test_reset_mid_run;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
